// File: rtl/fft_pkg.sv
// Shared types and default sizing for the radix-2 DIF FFT butterfly scheduler.
package fft_pkg;

  localparam int unsigned DEF_LOG2N  = 4;
  localparam int unsigned DEF_RD_LAT = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/fft_delay_line.sv
// Fixed-depth register pipeline with synchronous clear; aligns write strobes with read data return.
module fft_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 1) begin : g_one
    always_ff @(posedge clk) begin
      if (rst) begin
        q <= '0;
      end else begin
        q <= d;
      end
    end
  end else begin : g_many
    logic [DEPTH-1:0][WIDTH-1:0] pipe;

    always_ff @(posedge clk) begin
      if (rst) begin
        pipe <= '0;
      end else begin
        pipe <= {pipe[DEPTH-2:0], d};
      end
    end

    assign q = pipe[DEPTH-1];
  end

endmodule

// File: rtl/fft_bf_sched.sv
// In-place radix-2 DIF FFT butterfly address scheduler: issues N/2 butterflies per stage,
// drains the RAM read latency between stages, and replays the addresses as write strobes.
module fft_bf_sched
  import fft_pkg::*;
#(
  parameter int unsigned LOG2N  = DEF_LOG2N,
  parameter int unsigned RD_LAT = DEF_RD_LAT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       hold,
  output logic                       rd_en,
  output logic [LOG2N-1:0]           rd_addr_a,
  output logic [LOG2N-1:0]           rd_addr_b,
  output logic [LOG2N-2:0]           tw_addr,
  output logic                       wr_en,
  output logic [LOG2N-1:0]           wr_addr_a,
  output logic [LOG2N-1:0]           wr_addr_b,
  output logic [$clog2(LOG2N)-1:0]   stage,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned AW   = LOG2N;
  localparam int unsigned TW   = LOG2N - 1;
  localparam int unsigned SW   = $clog2(LOG2N);
  localparam int unsigned HALF = 1 << (LOG2N - 1);
  localparam int unsigned DW   = $clog2(RD_LAT + 1);
  localparam int unsigned LW   = 1 + 2 * AW;

  state_t          state_q, state_d;
  logic [AW-1:0]   j_q, j_d;
  logic [SW-1:0]   stage_q, stage_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  logic            issue;
  logic [AW-1:0]   iss_j;
  logic [AW-1:0]   span;
  logic [AW-1:0]   k;
  logic [AW-1:0]   a_d;
  logic [AW-1:0]   b_d;
  logic [TW-1:0]   tw_d;
  logic [LW-1:0]   line_q;

  // Next-state, butterfly counter and issue decision for the coming cycle
  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    stage_d = stage_q;
    dcnt_d  = dcnt_q;
    issue   = 1'b0;
    iss_j   = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          j_d     = '0;
          stage_d = '0;
          issue   = !hold;
        end
      end
      ST_RUN: begin
        if (j_q == AW'(HALF)) begin
          state_d = ST_DRAIN;
          dcnt_d  = DW'(1);
        end else begin
          issue = !hold;
        end
      end
      ST_DRAIN: begin
        if (dcnt_q == DW'(RD_LAT)) begin
          if (stage_q == SW'(LOG2N - 1)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
            stage_d = stage_q + SW'(1);
            j_d     = '0;
            issue   = !hold;
          end
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    iss_j = j_d;
    if (issue) begin
      j_d = iss_j + AW'(1);
    end

    // Group base is j with the in-group bits cleared, doubled; pair partner sits one span above
    span = AW'(HALF) >> stage_d;
    k    = iss_j & (span - AW'(1));
    a_d  = ((iss_j & ~(span - AW'(1))) << 1) | k;
    b_d  = a_d | span;
    tw_d = TW'(k << stage_d);
  end

  // FSM and counter state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      j_q     <= '0;
      stage_q <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      stage_q <= stage_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // Registered read-side outputs; addresses stay frozen between issues
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_addr   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      rd_en <= issue;
      if (issue) begin
        rd_addr_a <= a_d;
        rd_addr_b <= b_d;
        tw_addr   <= tw_d;
      end
      busy <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
      done <= (state_d == ST_DONE);
    end
  end

  assign stage = stage_q;

  fft_delay_line #(
    .WIDTH (LW),
    .DEPTH (RD_LAT)
  ) u_wr_delay (
    .clk (clk),
    .rst (rst),
    .d   ({rd_en, rd_addr_a, rd_addr_b}),
    .q   (line_q)
  );

  assign {wr_en, wr_addr_a, wr_addr_b} = line_q;

endmodule
